// File: rtl/csr_file.sv
// Machine-mode CSR file and interrupt trap unit: CSRRW/S/C access, mip synchronisers,
// trap entry/mret PC redirect. Define CSR_COUNTERS_EN to add 64-bit mcycle/minstret.
module csr_file #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_valid,
    input  logic [XLEN-1:0] pc,
    input  logic [11:0]     csr_addr,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] wdata,
    input  logic            csr_rd,
    input  logic            csr_wr,
    input  logic            is_mret,
    input  logic            timer_intr,
    input  logic            ext_intr,
    output logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] epc,
    output logic            epc_taken
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;
`ifdef CSR_COUNTERS_EN
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
    localparam logic [11:0] A_MINSTR   = 12'hB02;
    localparam logic [11:0] A_MINSTRH  = 12'hB82;
    localparam logic [2*XLEN-1:0] CNT_ONE = {{(2*XLEN-1){1'b0}}, 1'b1};
`endif

    logic            r_mstatus_mie;
    logic            r_mstatus_mpie;
    logic            r_mie_meie;
    logic            r_mie_mtie;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [1:0]      r_tsync;
    logic [1:0]      r_esync;
`ifdef CSR_COUNTERS_EN
    logic [2*XLEN-1:0] r_mcycle;
    logic [2*XLEN-1:0] r_minstret;
`endif

    logic            w_ext_pend;
    logic            w_tmr_pend;
    logic            w_trap;
    logic            w_mret;
    logic            w_wr;
    logic [3:0]      w_cause_code;
    logic [XLEN-1:0] w_cause;
    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_vec_off;
    logic [XLEN-1:0] w_old;
    logic [XLEN-1:0] w_new;
    logic            w_unused;

    assign w_unused = ^{funct3[2], pc[1:0]};

    // mip bits are the second synchroniser stage
    assign w_ext_pend   = r_esync[1] & r_mie_meie;
    assign w_tmr_pend   = r_tsync[1] & r_mie_mtie;
    assign w_trap       = r_mstatus_mie & (w_ext_pend | w_tmr_pend) & inst_valid & ~is_mret;
    assign w_mret       = is_mret & inst_valid;
    assign w_cause_code = w_ext_pend ? 4'd11 : 4'd7;
    assign w_cause      = {1'b1, {(XLEN-5){1'b0}}, w_cause_code};
    assign w_base       = {r_mtvec[XLEN-1:2], 2'b00};
    assign w_vec_off    = {{(XLEN-6){1'b0}}, w_cause_code, 2'b00};

    assign epc       = w_mret ? r_mepc
                     : ((r_mtvec[1:0] == 2'b01) ? (w_base + w_vec_off) : w_base);
    assign epc_taken = ~rst & (w_trap | w_mret);

    always_comb begin
        w_old = '0;
        case (csr_addr)
            A_MSTATUS: begin
                w_old[3] = r_mstatus_mie;
                w_old[7] = r_mstatus_mpie;
            end
            A_MIE: begin
                w_old[11] = r_mie_meie;
                w_old[7]  = r_mie_mtie;
            end
            A_MTVEC:  w_old = r_mtvec;
            A_MEPC:   w_old = r_mepc;
            A_MCAUSE: w_old = r_mcause;
            A_MIP: begin
                w_old[11] = r_esync[1];
                w_old[7]  = r_tsync[1];
            end
`ifdef CSR_COUNTERS_EN
            A_MCYCLE:  w_old = r_mcycle[XLEN-1:0];
            A_MCYCLEH: w_old = r_mcycle[2*XLEN-1:XLEN];
            A_MINSTR:  w_old = r_minstret[XLEN-1:0];
            A_MINSTRH: w_old = r_minstret[2*XLEN-1:XLEN];
`endif
            default:  w_old = '0;
        endcase
    end

    assign rdata = csr_rd ? w_old : '0;

    always_comb begin
        w_new = w_old;
        case (funct3[1:0])
            2'b01:   w_new = wdata;
            2'b10:   w_new = w_old | wdata;
            2'b11:   w_new = w_old & ~wdata;
            default: w_new = w_old;
        endcase
    end

    // A trapping instruction does not retire, so its CSR write is dropped
    assign w_wr = csr_wr & inst_valid & ~w_trap & (funct3[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie_meie     <= 1'b0;
            r_mie_mtie     <= 1'b0;
            r_mtvec        <= RESET_MTVEC;
            r_mepc         <= '0;
            r_mcause       <= '0;
            r_tsync        <= 2'b00;
            r_esync        <= 2'b00;
        end else begin
            r_tsync <= {r_tsync[0], timer_intr};
            r_esync <= {r_esync[0], ext_intr};
            if (w_trap) begin
                r_mepc         <= {pc[XLEN-1:2], 2'b00};
                r_mcause       <= w_cause;
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
            end else begin
                if (w_mret) begin
                    r_mstatus_mie  <= r_mstatus_mpie;
                    r_mstatus_mpie <= 1'b1;
                end else if (w_wr && csr_addr == A_MSTATUS) begin
                    r_mstatus_mie  <= w_new[3];
                    r_mstatus_mpie <= w_new[7];
                end
                if (w_wr) begin
                    case (csr_addr)
                        A_MIE: begin
                            r_mie_meie <= w_new[11];
                            r_mie_mtie <= w_new[7];
                        end
                        A_MTVEC:  r_mtvec  <= w_new;
                        A_MEPC:   r_mepc   <= {w_new[XLEN-1:2], 2'b00};
                        A_MCAUSE: r_mcause <= w_new;
                        default:  ;
                    endcase
                end
            end
        end
    end

`ifdef CSR_COUNTERS_EN
    // A software write to one half replaces that cycle's increment entirely
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
        end else begin
            if (w_wr && csr_addr == A_MCYCLE)
                r_mcycle[XLEN-1:0] <= w_new;
            else if (w_wr && csr_addr == A_MCYCLEH)
                r_mcycle[2*XLEN-1:XLEN] <= w_new;
            else
                r_mcycle <= r_mcycle + CNT_ONE;

            if (w_wr && csr_addr == A_MINSTR)
                r_minstret[XLEN-1:0] <= w_new;
            else if (w_wr && csr_addr == A_MINSTRH)
                r_minstret[2*XLEN-1:XLEN] <= w_new;
            else if (inst_valid && !w_trap)
                r_minstret <= r_minstret + CNT_ONE;
        end
    end
`endif

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: directed scenarios followed by random CSR traffic, all checked
// against an architectural model of the machine-mode CSRs kept in this file.
module tb_csr_file;

    localparam logic [31:0] RST_VEC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_valid = 1'b0;
    logic [31:0] pc = '0;
    logic [11:0] csr_addr = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] wdata = '0;
    logic        csr_rd = 1'b0;
    logic        csr_wr = 1'b0;
    logic        is_mret = 1'b0;
    logic        timer_intr = 1'b0;
    logic        ext_intr = 1'b0;
    logic [31:0] rdata;
    logic [31:0] epc;
    logic        epc_taken;

    always #5 clk = ~clk;

    csr_file #(.XLEN(32), .RESET_MTVEC(RST_VEC)) dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .pc(pc),
        .csr_addr(csr_addr), .funct3(funct3), .wdata(wdata),
        .csr_rd(csr_rd), .csr_wr(csr_wr), .is_mret(is_mret),
        .timer_intr(timer_intr), .ext_intr(ext_intr),
        .rdata(rdata), .epc(epc), .epc_taken(epc_taken)
    );

    int checks = 0;
    int errors = 0;

    // Architectural model state
    logic [31:0] m_mstatus = '0, m_mie = '0, m_mtvec = RST_VEC, m_mepc = '0, m_mcause = '0;
    logic [1:0]  m_t = '0, m_e = '0;   // [1] = level seen two edges ago
    logic [63:0] m_cyc = '0, m_ins = '0;

    logic [31:0] last_rdata, last_epc;
    logic        last_taken;

    logic [11:0] addrs [12] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344,
                                12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h123, 12'h7C0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return (m_e[1] ? 32'h800 : 32'h0) | (m_t[1] ? 32'h80 : 32'h0);
`ifdef CSR_COUNTERS_EN
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB02: return m_ins[31:0];
            12'hB82: return m_ins[63:32];
`endif
            default: return 32'h0;
        endcase
    endfunction

    // One instruction slot: drive, predict, compare, clock, advance the model
    task automatic cyc(input logic v, input logic [31:0] p, input logic [11:0] a,
                       input logic [2:0] f3, input logic [31:0] wd,
                       input logic rd, input logic wr, input logic mr);
        logic [31:0] old, nv, tgt, exp_epc;
        logic        ext_en, tmr_en, trap, mret, wen, exp_taken, t_in, e_in;
        int          code;
        inst_valid = v; pc = p; csr_addr = a; funct3 = f3; wdata = wd;
        csr_rd = rd; csr_wr = wr; is_mret = mr;
        #1;
        old       = m_read(a);
        ext_en    = m_e[1] && m_mie[11];
        tmr_en    = m_t[1] && m_mie[7];
        trap      = m_mstatus[3] && (ext_en || tmr_en) && v && !mr;
        mret      = mr && v;
        code      = ext_en ? 11 : 7;
        tgt       = (m_mtvec & ~32'd3) + ((m_mtvec % 4 == 1) ? 32'(4 * code) : 32'd0);
        exp_taken = !rst && (trap || mret);
        exp_epc   = mret ? m_mepc : tgt;
        check("rdata", rdata, rd ? old : 32'h0);
        check("epc_taken", {31'b0, epc_taken}, {31'b0, exp_taken});
        if (exp_taken) check("epc", epc, exp_epc);
        last_rdata = rdata; last_epc = epc; last_taken = epc_taken;
        t_in = timer_intr; e_in = ext_intr;
        @(posedge clk);
        if (rst) begin
            m_mstatus = '0; m_mie = '0; m_mtvec = RST_VEC; m_mepc = '0; m_mcause = '0;
            m_t = '0; m_e = '0; m_cyc = '0; m_ins = '0;
        end else begin
            wen = wr && v && !trap && (f3[1:0] != 2'b00);
            nv  = (f3[1:0] == 2'b01) ? wd : (f3[1:0] == 2'b10) ? (old | wd) : (old & ~wd);
            if (trap) begin
                m_mepc    = p & ~32'd3;
                m_mcause  = ext_en ? 32'h8000_000B : 32'h8000_0007;
                m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
            end else if (mret) begin
                m_mstatus = m_mstatus[7] ? 32'h88 : 32'h80;
            end
            if (wen) begin
                case (a)
                    12'h300: if (!mret) m_mstatus = nv & 32'h88;
                    12'h304: m_mie = nv & 32'h880;
                    12'h305: m_mtvec = nv;
                    12'h341: m_mepc = nv & ~32'd3;
                    12'h342: m_mcause = nv;
                    default: ;
                endcase
            end
`ifdef CSR_COUNTERS_EN
            if (wen && a == 12'hB00) m_cyc[31:0] = nv;
            else if (wen && a == 12'hB80) m_cyc[63:32] = nv;
            else m_cyc = m_cyc + 64'd1;
            if (wen && a == 12'hB02) m_ins[31:0] = nv;
            else if (wen && a == 12'hB82) m_ins[63:32] = nv;
            else if (v && !trap) m_ins = m_ins + 64'd1;
`endif
            m_t = {m_t[0], t_in};
            m_e = {m_e[0], e_in};
        end
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 12'h0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic rd_csr(input logic [11:0] a);
        cyc(1'b0, 32'h0, a, 3'b010, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask
    task automatic csr_op(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] wd,
                          input logic [31:0] p);
        cyc(1'b1, p, a, f3, wd, 1'b1, 1'b1, 1'b0);
    endtask
    task automatic exec(input logic [31:0] p);
        cyc(1'b1, p, 12'h0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic mret_op(input logic [31:0] p);
        cyc(1'b1, p, 12'h0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        @(negedge clk);
        // Reset, then every address reads zero
        rst = 1'b1;
        idle();
        idle();
        rst = 1'b0;
        foreach (addrs[i]) begin
            rd_csr(addrs[i]);
            check("reset_read", last_rdata, 32'h0);
        end
        idle();
        check("reset_epc", last_epc, RST_VEC);
        check("reset_taken", {31'b0, last_taken}, 32'h0);

        // Read-before-write on CSRRW
        csr_op(3'b001, 12'h305, 32'h0000_1000, 32'h100);
        check("rw_old_value", last_rdata, 32'h0);
        rd_csr(12'h305);
        check("mtvec_written", last_rdata, 32'h0000_1000);

        // Set and clear masked to writable mie bits
        csr_op(3'b001, 12'h304, 32'h0, 32'h104);
        csr_op(3'b010, 12'h304, 32'hFFFF_FFFF, 32'h108);
        rd_csr(12'h304);
        check("mie_set", last_rdata, 32'h0000_0880);
        csr_op(3'b011, 12'h304, 32'h0000_0080, 32'h10C);
        rd_csr(12'h304);
        check("mie_clear", last_rdata, 32'h0000_0800);

        // Timer trap after two-flop synchroniser latency
        csr_op(3'b001, 12'h304, 32'h80, 32'h110);
        csr_op(3'b001, 12'h300, 32'h8, 32'h114);
        timer_intr = 1'b1;
        idle();
        idle();
        exec(32'h200);
        check("timer_trap_taken", {31'b0, last_taken}, 32'h1);
        check("timer_trap_epc", last_epc, 32'h0000_1000);
        rd_csr(12'h341);
        check("timer_mepc", last_rdata, 32'h200);
        rd_csr(12'h342);
        check("timer_mcause", last_rdata, 32'h8000_0007);
        rd_csr(12'h300);
        check("timer_mstatus", last_rdata, 32'h80);

        // mret returns to mepc and restores MIE; pending timer then traps again
        mret_op(32'h1000);
        check("mret_taken", {31'b0, last_taken}, 32'h1);
        check("mret_epc", last_epc, 32'h200);
        rd_csr(12'h300);
        check("mret_mstatus", last_rdata, 32'h88);
        exec(32'h300);
        check("retrap_taken", {31'b0, last_taken}, 32'h1);

        // Vectored mode with both interrupts pending: external wins
        csr_op(3'b001, 12'h305, 32'h0000_1001, 32'h1000);
        csr_op(3'b001, 12'h304, 32'h880, 32'h1004);
        ext_intr = 1'b1;
        idle();
        idle();
        csr_op(3'b010, 12'h300, 32'h8, 32'h1008);
        exec(32'h400);
        check("vector_epc", last_epc, 32'h0000_102C);
        rd_csr(12'h342);
        check("ext_mcause", last_rdata, 32'h8000_000B);

        // Trap coincident with a CSRRW to mtvec: write suppressed
        mret_op(32'h102C);
        csr_op(3'b001, 12'h305, 32'h0000_5000, 32'h500);
        check("trap_wr_taken", {31'b0, last_taken}, 32'h1);
        rd_csr(12'h305);
        check("mtvec_kept", last_rdata, 32'h0000_1001);

`ifdef CSR_COUNTERS_EN
        csr_op(3'b001, 12'hB80, 32'h5, 32'h600);
        csr_op(3'b001, 12'hB00, 32'hFFFF_FFFF, 32'h604);
        rd_csr(12'hB80);
        check("mcycleh_before", last_rdata, 32'h5);
        rd_csr(12'hB00);
        check("mcycle_wrapped", last_rdata, 32'h0);
        rd_csr(12'hB80);
        check("mcycleh_carry", last_rdata, 32'h6);
`else
        csr_op(3'b001, 12'hB00, 32'h123, 32'h600);
        rd_csr(12'hB00);
        check("no_counter_lo", last_rdata, 32'h0);
        rd_csr(12'hB82);
        check("no_counter_hi", last_rdata, 32'h0);
`endif

        // Random traffic against the model
        timer_intr = 1'b0;
        ext_intr   = 1'b0;
        for (int n = 0; n < 600; n++) begin
            logic        v, r, w, m;
            logic [2:0]  f;
            logic [31:0] d;
            rst = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 15) == 0) timer_intr = ~timer_intr;
            if ($urandom_range(0, 15) == 0) ext_intr = ~ext_intr;
            v = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 1);
            w = $urandom_range(0, 1);
            m = ($urandom_range(0, 11) == 0);
            if (m) w = 1'b0;
            f = 3'($urandom);
            d = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 31));
            cyc(v, $urandom, addrs[$urandom_range(0, 11)], f, d, r, w, m);
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
